down_counter_reload_4b: RTL and testbench
=========================================

Name: down_counter_reload_4b

Overview:
- Loadable down-counter/timer, the decrementing counterpart of the 4-bit up-counter with snapshot storage.
- Holds a reload value, counts it down to zero on qualified ticks, then flags completion.
- Optionally reloads and repeats.
- Ticks come from the clock divider or are tied high for full-rate counting.

Parameters:
WIDTH, 4, counter and reload register width in bits
AUTO_RELOAD, 0, 1 = reload on terminal count and keep running; 0 = stop in IDLE

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  capture load_value into reload register (level-sampled each edge)
load_value  input  WIDTH  value to count down from
start  input  1  begin countdown from current count
pause  input  1  freeze count while high (RUN only)
abort  input  1  return to IDLE, count restored to reload register
tick  input  1  decrement enable; one decrement per edge with tick=1
count  output  WIDTH  current counter value (registered)
busy  output  1  high while in RUN
done  output  1  one-cycle pulse on terminal count

Behaviour:
- Reset (rst_n low, async): count=0, reload_reg=0, state=IDLE, busy=0, done=0. Immediate on assertion; leaving reset takes effect at the first edge after release. Reset mid-RUN discards all progress.
- State machine: IDLE, RUN. busy is the registered state (busy=1 iff state=RUN).
- done is registered, high exactly one cycle, and is otherwise 0.
- Priority when several controls are high on the same edge: abort > load > start > tick.
- IDLE:
  - load=1: reload_reg<=load_value and count<=load_value.
  - start=1 with count!=0: state<=RUN.
  - start=1 with count==0: done<=1 and the block stays IDLE (zero-length countdown).
  - tick and pause are ignored.
- RUN:
  - abort=1: state<=IDLE, count<=reload_reg, no done pulse.
  - load=1: reload_reg<=load_value only. count is unaffected; the new value applies at the next reload/abort/IDLE load.
  - start=1 is ignored (no restart).
  - pause=1: count holds and ticks are dropped, not queued.
  - tick=1, pause=0, count>1: count<=count-1.
  - tick=1, pause=0, count==1, AUTO_RELOAD=0: count<=0, done<=1, state<=IDLE. busy falls on the same edge done rises.
  - tick=1, pause=0, count==1, AUTO_RELOAD=1: count<=reload_reg, done<=1, state stays RUN.
  - If reload_reg==0 at that point: count<=0, done<=1, state<=IDLE (auto-reload cannot run a zero period).
- Latency:
  - start sampled at edge k gives busy=1 after edge k.
  - First decrement can occur at edge k+1.
  - With tick tied high, N loaded gives done asserted after edge k+N.
- Arithmetic: unsigned. count never wraps below 0; the count==1 terminal rule guarantees no underflow.
- Maximum period: 2^WIDTH-1 ticks (15 for WIDTH=4).
- All outputs are glitch-free registers; no combinational path from any input to any output.

Test Plan:
- Reset during RUN: load 9, start, 3 ticks (count=6), pulse rst_n low mid-cycle -> count=0, busy=0, done=0 immediately, before the next edge.
- Basic countdown: load 5, start, tick tied high -> count 5,4,3,2,1,0 on consecutive edges; done=1 for exactly the cycle count=0; busy falls the same edge; state IDLE.
- Pause and sparse ticks: load 4, start, tick every 2nd cycle, pause high for 3 cycles after count=3 -> count holds 3 during pause; done after 4 effective ticks; total elapsed cycles match the tick count.
- Auto-reload (AUTO_RELOAD=1): load 3, start, tick high -> count 3,2,1,3,2,1,3...; done pulses every 3rd edge; busy stays 1.
- Load during RUN: load 3, set load_value=7 with load high at count=2 -> count 2,1 then reloads to 7.
- Abort during RUN: load 6, start, 2 ticks (count=4), abort -> count=6, busy=0, no done.
- Edge cases:
  - start with count=0 -> single done pulse, busy stays 0.
  - load and start on the same edge in IDLE -> load wins, start ignored, count=load_value, still IDLE.
  - start while busy -> ignored, count unaffected.

Source files
------------

// File: rtl/down_counter_reload_4b.sv
// Loadable down-counter: counts the reload value to zero on ticks, pulses done, optionally reloads.
// Latency: busy one edge after start, done on the edge the last tick lands; no backpressure, paused ticks are dropped.
module down_counter_reload_4b #(
   parameter int WIDTH       = 4,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   input  logic             tick,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [0:0]       state;
   logic [WIDTH-1:0] reload_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         count      <= ZERO;
         reload_reg <= ZERO;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state <= IDLE;
            count <= reload_reg;
         end else if (state == IDLE) begin
            if (load) begin
               reload_reg <= load_value;
               count      <= load_value;
            end else if (start) begin
               if (count != ZERO) begin
                  state <= RUN;
               end else begin
                  done <= 1'b1;
               end
            end
         end else begin
            // In RUN a load only retargets the next period; it also consumes this edge's tick.
            if (load) begin
               reload_reg <= load_value;
            end else if (tick && !pause) begin
               if (count > ONE) begin
                  count <= count - ONE;
               end else if (count == ONE) begin
                  done <= 1'b1;
                  if (AUTO_RELOAD && (reload_reg != ZERO)) begin
                     count <= reload_reg;
                  end else begin
                     count <= ZERO;
                     state <= IDLE;
                  end
               end
            end
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter_reload_4b.sv
// Bench for down_counter_reload_4b: table vectors, corner sequences and random stimulus vs a reference model.
module tb_down_counter_reload_4b;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0, tick = 1'b0;
   logic [3:0] load_value = 4'd0;
   logic [3:0] count0, count1;
   logic       busy0, busy1, done0, done1;

   int errors = 0;
   int checks = 0;

   // Reference state per instance: [0] stops at terminal count, [1] auto-reloads.
   int m_cnt[2];
   int m_rel[2];
   bit m_run[2];
   bit m_done[2];

   always #5 clk = ~clk;

   down_counter_reload_4b #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .load(load), .load_value(load_value), .start(start),
      .pause(pause), .abort(abort), .tick(tick), .count(count0), .busy(busy0), .done(done0)
   );

   down_counter_reload_4b #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .load(load), .load_value(load_value), .start(start),
      .pause(pause), .abort(abort), .tick(tick), .count(count1), .busy(busy1), .done(done1)
   );

   typedef struct {
      bit       load;
      bit [3:0] lv;
      bit       start;
      bit       pause;
      bit       abort;
      bit       tick;
      int       cnt;
      bit       busy;
      bit       done;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_cnt[d] = 0; m_rel[d] = 0; m_run[d] = 1'b0; m_done[d] = 1'b0;
      end
   endtask

   task automatic model_update();
      for (int d = 0; d < 2; d++) begin
         m_done[d] = 1'b0;
         if (abort) begin
            m_run[d] = 1'b0;
            m_cnt[d] = m_rel[d];
         end else if (!m_run[d]) begin
            if (load) begin
               m_rel[d] = load_value;
               m_cnt[d] = load_value;
            end else if (start) begin
               if (m_cnt[d] == 0) m_done[d] = 1'b1;
               else m_run[d] = 1'b1;
            end
         end else if (load) begin
            m_rel[d] = load_value;
         end else if (tick && !pause) begin
            if (m_cnt[d] > 1) begin
               m_cnt[d] = m_cnt[d] - 1;
            end else begin
               m_done[d] = 1'b1;
               if (d == 1 && m_rel[d] != 0) begin
                  m_cnt[d] = m_rel[d];
               end else begin
                  m_cnt[d] = 0;
                  m_run[d] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic compare_models();
      check("m0_count", count0, m_cnt[0]);
      check("m0_busy", busy0, m_run[0]);
      check("m0_done", done0, m_done[0]);
      check("m1_count", count1, m_cnt[1]);
      check("m1_busy", busy1, m_run[1]);
      check("m1_done", done1, m_done[1]);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_models();
   endtask

   task automatic set_in(input bit l, input bit [3:0] lv, input bit s, input bit p,
                         input bit a, input bit t);
      load = l; load_value = lv; start = s; pause = p; abort = a; tick = t;
   endtask

   task automatic do_reset();
      set_in(0, 4'd0, 0, 0, 0, 0);
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check("rst_count", count0, 0);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      rst_n = 1'b1;
   endtask

   vec_t vecs[24];
   int   exp_seq[9];

   initial begin
      vecs = '{
         '{1, 4'd5, 0, 0, 0, 0, 5, 0, 0},  // load 5
         '{0, 4'd0, 1, 0, 0, 0, 5, 1, 0},  // start
         '{0, 4'd0, 0, 0, 0, 1, 4, 1, 0},
         '{0, 4'd0, 0, 0, 0, 1, 3, 1, 0},
         '{0, 4'd0, 0, 0, 0, 1, 2, 1, 0},
         '{0, 4'd0, 0, 0, 0, 1, 1, 1, 0},
         '{0, 4'd0, 0, 0, 0, 1, 0, 0, 1},  // terminal: done with busy falling
         '{0, 4'd0, 0, 0, 0, 0, 0, 0, 0},
         '{0, 4'd0, 1, 0, 0, 0, 0, 0, 1},  // zero-length countdown
         '{0, 4'd0, 0, 0, 0, 0, 0, 0, 0},
         '{1, 4'd3, 1, 0, 0, 0, 3, 0, 0},  // load beats start
         '{0, 4'd0, 1, 0, 0, 0, 3, 1, 0},
         '{0, 4'd0, 1, 0, 0, 1, 2, 1, 0},  // start while busy ignored
         '{0, 4'd0, 0, 0, 1, 0, 3, 0, 0},  // abort restores reload
         '{1, 4'd6, 0, 0, 0, 0, 6, 0, 0},
         '{0, 4'd0, 1, 0, 0, 1, 6, 1, 0},  // tick ignored in IDLE
         '{0, 4'd0, 0, 0, 0, 1, 5, 1, 0},
         '{0, 4'd0, 0, 0, 0, 1, 4, 1, 0},
         '{0, 4'd0, 0, 0, 1, 1, 6, 0, 0},  // abort beats tick, no done
         '{0, 4'd0, 1, 0, 0, 0, 6, 1, 0},
         '{0, 4'd0, 0, 1, 0, 1, 6, 1, 0},  // paused tick dropped
         '{1, 4'd2, 0, 0, 0, 1, 6, 1, 0},  // load in RUN leaves count
         '{0, 4'd0, 0, 0, 0, 1, 5, 1, 0},
         '{0, 4'd0, 0, 0, 1, 0, 2, 0, 0}   // abort picks up new reload
      };
      exp_seq = '{2, 1, 3, 2, 1, 3, 2, 1, 3};

      do_reset();

      foreach (vecs[i]) begin
         set_in(vecs[i].load, vecs[i].lv, vecs[i].start, vecs[i].pause, vecs[i].abort, vecs[i].tick);
         step();
         check($sformatf("vec%0d_count", i), count0, vecs[i].cnt);
         check($sformatf("vec%0d_busy", i), busy0, vecs[i].busy);
         check($sformatf("vec%0d_done", i), done0, vecs[i].done);
      end

      // Asynchronous reset in the middle of a run.
      do_reset();
      set_in(1, 4'd9, 0, 0, 0, 0); step();
      set_in(0, 4'd0, 1, 0, 0, 0); step();
      set_in(0, 4'd0, 0, 0, 0, 1); step(); step(); step();
      check("pre_rst_count", count0, 6);
      set_in(0, 4'd0, 0, 0, 0, 0);
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_count", count0, 0);
      check("async_rst_busy", busy0, 0);
      check("async_rst_done", done0, 0);
      #2 rst_n = 1'b1;

      // Auto-reload: period 3 with tick held high.
      set_in(1, 4'd3, 0, 0, 0, 0); step();
      set_in(0, 4'd0, 1, 0, 0, 0); step();
      set_in(0, 4'd0, 0, 0, 0, 1);
      for (int i = 0; i < 9; i++) begin
         step();
         check($sformatf("ar_count%0d", i), count1, exp_seq[i]);
         check($sformatf("ar_done%0d", i), done1, (i % 3) == 2);
         check($sformatf("ar_busy%0d", i), busy1, 1);
      end

      // Auto-reload with a zero reload value falls back to IDLE.
      set_in(1, 4'd0, 0, 0, 0, 0); step();
      set_in(0, 4'd0, 0, 0, 0, 1);
      while (count1 != 4'd1) step();
      step();
      check("ar_zero_count", count1, 0);
      check("ar_zero_done", done1, 1);
      check("ar_zero_busy", busy1, 0);

      // Pause with sparse ticks: 4 effective ticks.
      do_reset();
      set_in(1, 4'd4, 0, 0, 0, 0); step();
      set_in(0, 4'd0, 1, 0, 0, 0); step();
      for (int c = 0; c < 14; c++) begin
         set_in(0, 4'd0, 0, (c >= 2 && c < 5), 0, (c % 2) == 1);
         step();
         if (c == 4) check("pause_hold", count0, 3);
      end
      check("sparse_end_count", count0, 0);

      // Randomized traffic against the reference model.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         set_in($urandom_range(7, 0) == 0, 4'($urandom_range(15, 0)), $urandom_range(3, 0) == 0,
                $urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0, $urandom_range(1, 0) == 1);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
